// File: rtl/load_unit.sv
// Load unit: fetches one aligned word, then extracts and extends the addressed byte/halfword/word.
// Define LOAD_MISALIGN_CHECK_EN to reject misaligned lh/lhu/lw with an err pulse instead of loading.
module load_unit #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [2:0]  loadtype,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] result,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] LtLb  = 3'b000;
    localparam logic [2:0] LtLh  = 3'b001;
    localparam logic [2:0] LtLw  = 3'b010;
    localparam logic [2:0] LtLbu = 3'b100;
    localparam logic [2:0] LtLhu = 3'b101;

    localparam logic [7:0] WaitMaxC = 8'(WAIT_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StErr
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [2:0]  lt_q;
    logic [7:0]  wait_q;
    logic [7:0]  wait_inc;

    logic        type_ok;
    logic        misaligned;
    logic        reject;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    assign mem_addr = {addr_q[31:2], 2'b00};
    assign wait_inc = wait_q + 8'd1;

    // Decision made on the live inputs so a bad request never reaches REQ.
    always_comb begin
        type_ok = (loadtype == LtLb) || (loadtype == LtLh) || (loadtype == LtLw) ||
                  (loadtype == LtLbu) || (loadtype == LtLhu);
`ifdef LOAD_MISALIGN_CHECK_EN
        misaligned = (((loadtype == LtLh) || (loadtype == LtLhu)) && addr[0]) ||
                     ((loadtype == LtLw) && (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        reject = !type_ok || misaligned;
    end

    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lt_q)
            LtLb:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            LtLh:    ext_data = {{16{half_sel[15]}}, half_sel};
            LtLbu:   ext_data = {24'h000000, byte_sel};
            LtLhu:   ext_data = {16'h0000, half_sel};
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            lt_q    <= 3'b000;
            wait_q  <= 8'h00;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            result  <= 32'h0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q <= addr;
                        lt_q   <= loadtype;
                        busy   <= 1'b1;
                        if (reject) begin
                            state_q <= StErr;
                        end else begin
                            state_q <= StReq;
                            mem_req <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        result  <= ext_data;
                        wait_q  <= 8'h00;
                        mem_req <= 1'b0;
                        state_q <= StDone;
                    end else if (wait_inc == WaitMaxC) begin
                        // mem_req has now been up for WAIT_MAX cycles.
                        wait_q  <= 8'h00;
                        mem_req <= 1'b0;
                        state_q <= StErr;
                    end else begin
                        wait_q <= wait_inc;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                StErr: begin
                    busy    <= 1'b0;
                    err     <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(done && err));
    assert property (@(posedge clk) disable iff (!reset_n) mem_req |-> busy);

endmodule

// File: tb/tb_load_unit.sv
// Randomized scoreboard bench for load_unit: stimulus task pushes expected pulses, a monitor pops them.
`timescale 1ns/1ps
module tb_load_unit;

    localparam int unsigned WAIT_MAX = 15;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [2:0]  loadtype = 3'b000;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] result;
    logic        done;
    logic        err;

    load_unit #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .addr      (addr),
        .loadtype  (loadtype),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .result    (result),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_eps = 0;
    int          req_eps = 0;
    logic        req_prev = 1'b0;
    logic [31:0] model_res = 32'h0;
    logic [2:0]  codes [5] = '{LB, LH, LW, LBU, LHU};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic void chk_bit(string name, logic act, logic expv);
        chk(name, {31'h0, act}, {31'h0, expv});
    endfunction

    function automatic bit legal(logic [2:0] lt);
        return (lt == LB) || (lt == LH) || (lt == LW) || (lt == LBU) || (lt == LHU);
    endfunction

    function automatic bit misaligned(logic [31:0] a, logic [2:0] lt);
`ifdef LOAD_MISALIGN_CHECK_EN
        if ((lt == LH || lt == LHU) && a[0]) return 1'b1;
        if (lt == LW && a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Reference extraction by shifting and masking the little-endian word.
    function automatic logic [31:0] extend(logic [31:0] w, logic [31:0] a, logic [2:0] lt);
        logic [31:0] v;
        case (lt)
            LB, LBU: begin
                v = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
                if (lt == LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            LH, LHU: begin
                v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
                if (lt == LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic do_load(input logic [31:0] a, input logic [2:0] lt, input logic [31:0] rd,
                           input int lat, input bit hammer);
        int   n;
        bit   bad;
        bit   acked;
        exp_t e;
        start     = 1'b1;
        addr      = a;
        loadtype  = lt;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        @(posedge clk);
        #1;
        n        = cyc;
        start    = hammer;
        addr     = $urandom;
        loadtype = 3'($urandom);
        bad      = !legal(lt) || misaligned(a, lt);
        acked    = 1'b0;
        if (bad) begin
            start   = 1'b0;
            mem_ack = 1'b0;
            chk_bit("no_req_on_reject", mem_req, 1'b0);
            e = '{is_err: 1'b1, res: model_res, at: n + 1};
            sb.push_back(e);
        end else begin
            exp_eps++;
            for (int i = 0; i < int'(WAIT_MAX); i++) begin
                chk_bit("mem_req_high", mem_req, 1'b1);
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                mem_ack   = (i == lat);
                mem_rdata = (i == lat) ? rd : $urandom;
                @(posedge clk);
                #1;
                if (i == lat) begin
                    acked = 1'b1;
                    break;
                end
            end
            start     = 1'b0;
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            chk_bit("mem_req_low", mem_req, 1'b0);
            if (acked) begin
                model_res = extend(rd, a, lt);
                e = '{is_err: 1'b0, res: model_res, at: n + 2 + lat};
            end else begin
                e = '{is_err: 1'b1, res: model_res, at: n + 1 + int'(WAIT_MAX)};
            end
            sb.push_back(e);
        end
        for (int k = 0; k < 4 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        if (busy) chk_bit("return_to_idle", busy, 1'b0);
        mem_ack = 1'b0;
    endtask

    // Monitor: every done/err pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (done || err) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", {30'h0, done, err}, 32'h0);
                    end else begin
                        e = sb.pop_front();
                        chk_bit("pulse_kind_err", err, e.is_err);
                        chk_bit("pulse_kind_done", done, !e.is_err);
                        chk("result", result, e.res);
                        chk("pulse_cycle", cyc, e.at);
                    end
                end
                if (mem_req && !req_prev) req_eps++;
            end
            req_prev = mem_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] lt;
        int         lat;
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_result", result, 32'h0);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_err", err, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_load(32'h0000_1003, LB, 32'h80FF_1234, 0, 1'b0);
        chk("lb_sext", result, 32'hFFFF_FF80);
        do_load(32'h0000_2002, LHU, 32'hBEEF_0001, 1, 1'b0);
        chk("lhu_zext", result, 32'h0000_BEEF);
        do_load(32'h0000_2002, LH, 32'hBEEF_0001, 2, 1'b0);
        chk("lh_sext", result, 32'hFFFF_BEEF);
        do_load(32'h0000_3000, LW, 32'h1234_5678, int'(WAIT_MAX), 1'b0);
        chk("timeout_result_held", result, 32'hFFFF_BEEF);
        chk_bit("timeout_busy", busy, 1'b0);
        do_load(32'h0000_3001, LW, 32'hCAFE_F00D, 0, 1'b0);
`ifdef LOAD_MISALIGN_CHECK_EN
        chk("misalign_result_held", result, 32'hFFFF_BEEF);
`else
        chk("misalign_lw_word", result, 32'hCAFE_F00D);
`endif
        do_load(32'h0000_7006, LHU, 32'h8001_7FFE, int'(WAIT_MAX) - 1, 1'b0);
        chk("last_cycle_ack", result, 32'h0000_8001);
        do_load(32'h0000_4000, LW, 32'hA5A5_5A5A, 4, 1'b1);
        chk("hammer_result", result, 32'hA5A5_5A5A);
        do_load(32'h0000_5004, 3'b011, 32'h1111_1111, 0, 1'b0);
        chk("illegal_result_held", result, 32'hA5A5_5A5A);

        // Reset in the middle of REQ aborts silently.
        start    = 1'b1;
        addr     = 32'h0000_6008;
        loadtype = LW;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_eps++;
        chk_bit("abort_req_high", mem_req, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_bit("abort_mem_req", mem_req, 1'b0);
        chk_bit("abort_busy", busy, 1'b0);
        chk("abort_result", result, 32'h0);
        model_res = 32'h0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_load(32'h0000_6008, LW, 32'h0BAD_F00D, 0, 1'b0);
        chk("after_abort", result, 32'h0BAD_F00D);

        for (int t = 0; t < 200; t++) begin
            lt  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : codes[$urandom_range(0, 4)];
            lat = ($urandom_range(0, 7) == 0) ? int'(WAIT_MAX) : int'($urandom_range(0, 5));
            do_load($urandom, lt, $urandom, lat, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'h0);
        chk("req_episodes", req_eps, exp_eps);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
